// File: rtl/line_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : line_mem_arbiter
// Purpose : Serialises I-refill, D-refill and D-writeback line transactions
//           onto one single-ported, multi-cycle backing line memory.
// Option  : define ARB_STARVE_GUARD_EN to enable the I-side starvation guard.
// Rev     : 1.0 - initial release
// ============================================================================
module line_mem_arbiter #(
  parameter int LINE_W     = 128,
  parameter int LADDR_W    = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Ic_mem_req,
  input  logic [LADDR_W-1:0] Ic_mem_addr,
  output logic [LINE_W-1:0]  F_mem_inst,
  output logic               F_mem_valid,
  input  logic               Dc_mem_req,
  input  logic [LADDR_W-1:0] Dc_mem_addr,
  output logic [LINE_W-1:0]  MEM_data_line,
  output logic               MEM_mem_valid,
  input  logic               Dc_wb_we,
  input  logic [LADDR_W-1:0] Dc_wb_addr,
  input  logic [LINE_W-1:0]  Dc_wb_wline,
  output logic               Dc_wb_ack,
  output logic               Bm_req,
  output logic               Bm_we,
  output logic [LADDR_W-1:0] Bm_addr,
  output logic [LINE_W-1:0]  Bm_wline,
  input  logic [LINE_W-1:0]  Bm_rline,
  input  logic               Bm_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] I_RD = 2'd1;
  localparam logic [1:0] D_RD = 2'd2;
  localparam logic [1:0] D_WB = 2'd3;

  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_check
    $error("STARVE_MAX must fit the 3-bit starvation counter (1..7)");
  end

  logic [1:0]         r_state;
  logic               r_bm_req;
  logic               r_bm_we;
  logic [LADDR_W-1:0] r_bm_addr;
  logic [LINE_W-1:0]  r_bm_wline;

  logic [1:0]         w_grant;
  logic [LADDR_W-1:0] w_grant_addr;
  logic               w_i_forced;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

  logic [2:0] r_starve;

  assign w_i_forced = Ic_mem_req && (r_starve >= c_starve_max);

  // Counts D-side grants made while the I-side is left waiting; saturates at 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= 3'd0;
    end else if (r_state == IDLE) begin
      if (w_grant == I_RD) begin
        r_starve <= 3'd0;
      end else if ((w_grant == D_RD || w_grant == D_WB) && Ic_mem_req && r_starve != 3'd7) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end
`else
  assign w_i_forced = 1'b0;
`endif

  // Writeback wins so a refill of a just-evicted line sees the fresh data.
  always_comb begin
    w_grant = IDLE;
    if (w_i_forced) begin
      w_grant = I_RD;
    end else if (Dc_wb_we) begin
      w_grant = D_WB;
    end else if (Dc_mem_req) begin
      w_grant = D_RD;
    end else if (Ic_mem_req) begin
      w_grant = I_RD;
    end
  end

  always_comb begin
    w_grant_addr = Ic_mem_addr;
    if (w_grant == D_WB) begin
      w_grant_addr = Dc_wb_addr;
    end else if (w_grant == D_RD) begin
      w_grant_addr = Dc_mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bm_req   <= 1'b0;
      r_bm_we    <= 1'b0;
      r_bm_addr  <= '0;
      r_bm_wline <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != IDLE) begin
            r_state   <= w_grant;
            r_bm_req  <= 1'b1;
            r_bm_we   <= (w_grant == D_WB);
            r_bm_addr <= w_grant_addr;
            if (w_grant == D_WB) begin
              r_bm_wline <= Dc_wb_wline;
            end
          end
        end
        default: begin
          // Upstream inputs are not looked at until the memory completes.
          if (Bm_valid) begin
            r_state  <= IDLE;
            r_bm_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Bm_req   = r_bm_req;
  assign Bm_we    = r_bm_we;
  assign Bm_addr  = r_bm_addr;
  assign Bm_wline = r_bm_wline;

  assign F_mem_valid   = Bm_valid && (r_state == I_RD);
  assign MEM_mem_valid = Bm_valid && (r_state == D_RD);
  assign Dc_wb_ack     = Bm_valid && (r_state == D_WB);

  assign F_mem_inst    = F_mem_valid   ? Bm_rline : '0;
  assign MEM_data_line = MEM_mem_valid ? Bm_rline : '0;

endmodule
`default_nettype wire

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Sits between the I-cache/D-cache line interfaces and a single-ported, multi-cycle backing line memory.
- Replaces direct dual-port access to the memory.
- Serialises I-refill, D-refill and D-writeback transactions, one at a time, with fixed priority and an optional starvation guard.
- Upstream handshakes match the existing cache line-request signalling: level request held until a one-cycle valid/ack.

Parameters:
- LINE_W, 128, line width in bits
- LADDR_W, 10, line address width
- STARVE_MAX, 4, consecutive D-side grants allowed while I-side is waiting (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- Ic_mem_req  in  1  I-cache refill request, level, held until F_mem_valid
- Ic_mem_addr  in  LADDR_W  I-cache refill line address
- F_mem_inst  out  LINE_W  refill line to I-cache
- F_mem_valid  out  1  one-cycle pulse, I refill complete
- Dc_mem_req  in  1  D-cache refill request, level, held until MEM_mem_valid
- Dc_mem_addr  in  LADDR_W  D-cache refill line address
- MEM_data_line  out  LINE_W  refill line to D-cache
- MEM_mem_valid  out  1  one-cycle pulse, D refill complete
- Dc_wb_we  in  1  D-cache writeback request, level, held until Dc_wb_ack
- Dc_wb_addr  in  LADDR_W  writeback line address
- Dc_wb_wline  in  LINE_W  writeback line data
- Dc_wb_ack  out  1  one-cycle pulse, writeback committed
- Bm_req  out  1  backing-memory request, held until Bm_valid
- Bm_we  out  1  1 = write, 0 = read; stable while Bm_req is high
- Bm_addr  out  LADDR_W  backing-memory line address; stable while Bm_req is high
- Bm_wline  out  LINE_W  write data; stable while Bm_req is high
- Bm_rline  in  LINE_W  read data; valid when Bm_valid is high
- Bm_valid  in  1  one-cycle completion pulse from backing memory

Behaviour:
- FSM states: IDLE, I_RD, D_RD, D_WB.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Bm_req, Bm_we, Bm_addr, Bm_wline = 0.
  - Starve counter = 0.
  - All upstream valid/ack = 0.
  - F_mem_inst and MEM_data_line = 0.
- IDLE arbitration, evaluated on each clock edge; priority is Dc_wb_we > Dc_mem_req > Ic_mem_req.
  - Writeback goes first, so a refill of a just-evicted line reads fresh data.
- Grant at edge t:
  - Register Bm_addr, Bm_we and Bm_wline (wline for writes only) from the granted requester.
  - Bm_req=1 from cycle t+1. Minimum one idle cycle between grants is not required.
- Granted state holds until Bm_valid=1.
  - Upstream inputs are ignored during this time. Address/data changes mid-transaction do not affect Bm_* outputs.
- Completion in the cycle Bm_valid=1:
  - The matching upstream strobe is combinational: F_mem_valid = Bm_valid & (state==I_RD); likewise MEM_mem_valid for D_RD and Dc_wb_ack for D_WB.
  - Read data passes through: F_mem_inst = Bm_rline and MEM_data_line = Bm_rline while the respective valid is high; 0 otherwise.
  - At the next edge: state→IDLE, Bm_req→0.
  - Requesters drop req on that same edge, so IDLE at t+1 sees their updated req. The completed request is never re-granted.
- A new grant may occur at the first edge after returning to IDLE.
  - Back-to-back transactions therefore have Bm_req low for exactly one cycle between them.
- Bm_valid arriving in IDLE is ignored: no strobe, no state change.
- Simultaneous requests: all are served in priority order, one per transaction. Lower-priority requests stay pending and are not lost.
- Reset mid-transaction: the transaction is abandoned, state returns to IDLE and no strobe is generated. The backing memory is reset by the same rst.

Optional Feature:
- ARB_STARVE_GUARD_EN defined:
  - A 3-bit saturating counter counts consecutive D-side grants (D_RD or D_WB) made while Ic_mem_req=1.
  - When the counter reaches STARVE_MAX and Ic_mem_req=1, the next IDLE grant goes to I_RD regardless of D requests.
  - The counter clears on any I_RD grant and on reset.
- Not defined: strict fixed priority, no counter logic present; the I-side can starve indefinitely.

Test Plan:
- Single I refill: Ic_mem_req=1, addr=0x005; backing memory returns 0xA5..A5 after 3 cycles → Bm_req rises one cycle after grant with Bm_addr=0x005, Bm_we=0; F_mem_valid pulses for 1 cycle with F_mem_inst=0xA5..A5; Bm_req low the next cycle.
- Priority: Dc_wb_we (addr 0x010), Dc_mem_req (0x010) and Ic_mem_req (0x002) all raised in the same cycle → order is write(0x010, Bm_we=1, Dc_wb_ack), then read(0x010, MEM_mem_valid), then read(0x002, F_mem_valid); each request is acked exactly once.
- Hold stability: change Dc_mem_addr from 0x003 to 0x3FF mid-transaction → Bm_addr stays 0x003 until Bm_valid.
- Spurious Bm_valid pulsed in IDLE → no upstream strobe, state stays IDLE.
- Reset mid D_WB: rst=0 two cycles after grant → Bm_req=0 immediately (asynchronous); Dc_wb_ack never pulses; after release, the held Dc_wb_we is re-granted.
- With ARB_STARVE_GUARD_EN and STARVE_MAX=4: Dc_mem_req continuously re-requested and Ic_mem_req held → the 5th grant is I_RD. Without the macro, F_mem_valid never fires during the D-side stream.
